// File: rtl/inertial_delay_pkg.sv
// Shared types and helpers for the inertial delay filter.
// The optional drop counter is enabled with the DROP_CNT_EN macro.
package inertial_delay_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_CNT_W = 8;

    // A requested hold length of zero behaves as a single edge.
    function automatic logic [31:0] max_one(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared only by the asynchronous reset.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/inertial_delay_filter.sv
// Clocked inertial delay: di reaches dout only after holding for dq edges.
// Define DROP_CNT_EN to add the saturating drop_cnt output.
module inertial_delay_filter
    import inertial_delay_pkg::*;
#(
    parameter int   DW    = DEF_DW,
    parameter logic INIT  = 1'b0,
    parameter int   CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          di,
    input  logic [DW-1:0] dly,
    output logic          dout,
    output logic          busy,
    output logic          rise,
    output logic          fall,
    output logic          drop
`ifdef DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    state_t        state;
    logic [DW-1:0] cnt;
    logic [DW-1:0] dq;
    logic [DW-1:0] dly_eff;
    logic [DW-1:0] next_cnt;
    logic [DW-1:0] eff_dq;
    logic          differ;
    logic          accept;
    logic          drop_ev;

    assign dly_eff = DW'(max_one(32'(dly)));

    // A fresh entry into PENDING compares against the live dly; later edges use the latched dq.
    always_comb begin
        next_cnt = DW'(1);
        eff_dq   = dly_eff;
        if (state == PENDING) begin
            next_cnt = cnt + 1'b1;
            eff_dq   = dq;
        end
        differ  = (di != dout);
        accept  = differ && (next_cnt == eff_dq);
        drop_ev = !differ && (state == PENDING);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= STABLE;
            cnt   <= '0;
            dq    <= DW'(1);
            dout  <= INIT;
            busy  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            drop  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            drop <= drop_ev;
            if (differ) begin
                if (state == STABLE) begin
                    dq <= dly_eff;
                end
                if (accept) begin
                    dout  <= di;
                    state <= STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    rise  <= di;
                    fall  <= ~di;
                end else begin
                    state <= PENDING;
                    cnt   <= next_cnt;
                    busy  <= 1'b1;
                end
            end else begin
                state <= STABLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end
        end
    end

`ifdef DROP_CNT_EN
    // Counting the same edge that raises drop keeps drop_cnt aligned with the strobe.
    sat_counter #(
        .CNT_W(CNT_W)
    ) u_drop_cnt (
        .clk (clk),
        .rstn(rstn),
        .inc (drop_ev),
        .cnt (drop_cnt)
    );
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: doc/inertial_delay_filter.md
# inertial_delay_filter

- Synthesizable, clocked counterpart of the inertial wire delay used in our delay demos.
- Passes a single-bit synchronous level `di` to `dout` only after `di` has held its new value for a runtime-selected number of consecutive clock edges.
- Shorter pulses are swallowed and reported.
- Sits after input synchronizers as a deglitcher/debouncer, and serves as a cycle-accurate reference for delay experiments.

## Interface
Parameters:
- DW, 8, width of the `dly` input.
- INIT, 1'b0, reset value of `dout`.
- CNT_W, 8, width of the drop counter (only used with DROP_CNT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  reset, asynchronous and active-low.
- di  input  1  filtered input level, synchronous to clk.
- dly  input  DW  required hold length in edges; 0 is treated as 1.
- dout  output  1  filtered level.
- busy  output  1  high while a candidate change is pending.
- rise  output  1  one-cycle strobe, dout went 0->1.
- fall  output  1  one-cycle strobe, dout went 1->0.
- drop  output  1  one-cycle strobe, a pending change was swallowed.
- drop_cnt  output  CNT_W  saturating count of drops (present only with DROP_CNT_EN).

## Operation
- Two states:
  - STABLE: di == dout, cnt = 0.
  - PENDING: di differed from dout at the last edge; cnt counts consecutive differing edges.
- Effective delay `dq`:
  - Latched as max(dly,1) at the edge entering PENDING.
  - `dly` changes during PENDING are ignored until the next entry.
- At each edge, with next = (state==PENDING ? cnt+1 : 1):
  - di != dout and next == dq: dout <= di, state STABLE, cnt 0; rise or fall pulses next cycle.
  - di != dout and next < dq: state PENDING, cnt <= next, busy high.
  - di == dout and state PENDING: state STABLE, cnt 0, drop pulses next cycle.
  - di == dout and state STABLE: hold.
- dq == 1: dout follows di with one registered cycle; drops are impossible.
- cnt width DW. dq <= 2^DW-1, so no wrap.
- rise, fall and drop are mutually exclusive in any cycle.
- busy = (state == PENDING), registered.

## Timing
- Reset (rstn low, asynchronous): dout = INIT, state STABLE, cnt 0, dq 1, busy/rise/fall/drop 0, drop_cnt 0.
- Reset deassertion takes effect at the next rising edge. No glitch on outputs during reset.
- Latency: di changes before edge k and is held through edge k+dq-1. dout changes at edge k+dq-1, i.e. dq edges of sampling.
- A pulse sampled on fewer than dq edges never reaches dout. drop asserts the cycle after the edge where di returns.
- Consecutive opposite changes: after dout updates, a new difference starts a fresh PENDING at the following edge, with dly re-latched.
- Reset mid-PENDING: the pending change is discarded, dout returns to INIT, and no drop is reported.

## Configuration
- DROP_CNT_EN: compiles in the `drop_cnt` port and a CNT_W-bit counter.
  - Increments on every drop strobe.
  - Saturates at all-ones and clears only on reset.
- Without the macro: no counter, no port. The drop strobe is unaffected.

## Structure
- Package inertial_delay_pkg holds:
  - the state enum (STABLE, PENDING);
  - default DW/CNT_W constants;
  - a function returning max(dly,1).
- One sub-module: sat_counter (CNT_W parameter, inc, clear-on-reset, saturating). Instantiated only under DROP_CNT_EN.

## Test plan
- Reset with INIT=0 and then INIT=1, di toggling: dout equals INIT and all strobes are 0 during reset. dout is released only after the hold rule is met.
- dly=20, di 0->1 held 35 cycles: busy high for 19 cycles, dout rises at the 20th sampled edge, rise is one cycle. The 1->0 change is held 20 cycles and falls the same way.
- dly=20, di high 10 cycles: dout stays 0, drop pulses once, and drop_cnt increments by 1 (with DROP_CNT_EN).
- dly=0 and dly=1: dout follows di one cycle late and drop never asserts, even for single-cycle pulses.
- dly changed 20->5 mid-PENDING: the current change still needs 20 edges, and the next change needs 5.
- rstn asserted 3 cycles into PENDING with dly=8: dout = INIT immediately, no drop. With DROP_CNT_EN, drop_cnt saturates at 255 after 300 swallowed pulses.
